// File: rtl/peridot_uart_rxbuf.sv
// PERIDOT host-bridge UART receiver: 2-FF rxd sync, 8N1 deframer, show-ahead byte FIFO.
// Define PERIDOT_UART_RX_PARITY_EN to add a parity bit (8E1/8O1 selected by PARITY_ODD).
module peridot_uart_rxbuf #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int UART_BAUDRATE   = 115200,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int PARITY_ODD      = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       overrun,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int DIV = (CLOCK_FREQUENCY + UART_BAUDRATE / 2) / UART_BAUDRATE;
  localparam int CW  = (DIV < 4) ? 2 : $clog2(DIV);
  localparam int AW  = FIFO_DEPTH_LOG2;
  localparam int N   = 1 << FIFO_DEPTH_LOG2;

  localparam logic [CW-1:0] CNT_FULL   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(DIV / 2 - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(N);

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
`ifdef PERIDOT_UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd5;
`endif

  if (DIV < 4) begin : g_bad_div
    $error("peridot_uart_rxbuf: baud divisor %0d is below 4", DIV);
  end
  if (FIFO_DEPTH_LOG2 < 1 || FIFO_DEPTH_LOG2 > 6) begin : g_bad_depth
    $error("peridot_uart_rxbuf: FIFO_DEPTH_LOG2 %0d outside 1..6", FIFO_DEPTH_LOG2);
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("peridot_uart_rxbuf: PARITY_ODD must be 0 or 1");
  end

  logic          rxd_meta;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          tick;
  logic          stop_tick;
  logic          par_bad;
  logic          push;
  logic          pop;
  logic          full;
  logic          accept;

  logic [7:0]    mem [N];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
    end
  end

  assign tick      = (cnt == '0);
  assign stop_tick = (state == S_STOP) && tick;

`ifdef PERIDOT_UART_RX_PARITY_EN
  logic par_bit;
  assign par_bad = par_bit ^ (^shreg) ^ PARITY_ODD[0];
`else
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_WAIT_IDLE;
      cnt           <= '0;
      bitcnt        <= '0;
      shreg         <= '0;
      framing_error <= 1'b0;
`ifdef PERIDOT_UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      framing_error <= 1'b0;
`ifdef PERIDOT_UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      cnt <= cnt - CW'(1);
      case (state)
        S_WAIT_IDLE: if (rxs) state <= S_IDLE;
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= CNT_HALF;
          end
        end
        S_START: begin
          if (tick) begin
            if (!rxs) begin
              state  <= S_DATA;
              cnt    <= CNT_FULL;
              bitcnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg  <= {rxs, shreg[7:1]};
            cnt    <= CNT_FULL;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
`ifdef PERIDOT_UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef PERIDOT_UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            par_bit <= rxs;
            cnt     <= CNT_FULL;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Leaving at mid-stop lets the next start edge be caught without slip.
          if (tick) begin
            framing_error <= !rxs;
`ifdef PERIDOT_UART_RX_PARITY_EN
            parity_error  <= par_bad;
`endif
            state <= rxs ? S_IDLE : S_WAIT_IDLE;
          end
        end
        default: state <= S_WAIT_IDLE;
      endcase
    end
  end

  assign push      = stop_tick && rxs && !par_bad;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == FULL_COUNT);
  assign accept    = push && (!full || pop);
  assign rd_next   = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_next;
      if (accept && !pop)      count <= count + (AW + 1)'(1);
      else if (!accept && pop) count <= count - (AW + 1)'(1);
      // Registered head: bypass the incoming byte when it becomes the new head.
      if (pop) begin
        if (count == (AW + 1)'(1)) begin
          if (accept) out_data <= shreg;
        end else begin
          out_data <= mem[rd_next];
        end
      end else if (count == '0 && accept) begin
        out_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_peridot_uart_rxbuf.sv
// Self-checking bench for peridot_uart_rxbuf: frame-level model of delivered bytes and strobes.
module tb_peridot_uart_rxbuf;

  localparam int CLK_HZ     = 1000000;
  localparam int BAUD       = 100000;
  localparam int DEPTH_LOG2 = 2;
  localparam int PAR_ODD    = 0;
  localparam int DIV        = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int N          = 1 << DEPTH_LOG2;
`ifdef PERIDOT_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NB     = 10;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NB     = 9;
`endif
  // Start-edge drive to strobe visibility: 2 sync stages, edge detect, half bit, NB bits, registered push.
  localparam int LAT = 3 + DIV / 2 + NB * DIV;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       overrun;
  logic       framing_error;
  logic       parity_error;

  int vectors;
  int miscompares;
  int cyc;

  logic [7:0] got_q[$];
  int n_valid, first_valid;
  int n_ovr, ovr_cyc, n_fe, fe_cyc, n_pe, pe_cyc;

  peridot_uart_rxbuf #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .UART_BAUDRATE  (BAUD),
    .FIFO_DEPTH_LOG2(DEPTH_LOG2),
    .PARITY_ODD     (PAR_ODD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .overrun      (overrun),
    .framing_error(framing_error),
    .parity_error (parity_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      n_valid++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (overrun)       begin n_ovr++; ovr_cyc = cyc; end
    if (framing_error) begin n_fe++;  fe_cyc  = cyc; end
    if (parity_error)  begin n_pe++;  pe_cyc  = cyc; end
  end

  task automatic clear_log();
    got_q.delete();
    n_valid = 0; first_valid = -1;
    n_ovr = 0; n_fe = 0; n_pe = 0;
    ovr_cyc = -1; fe_cyc = -1; pe_cyc = -1;
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par,
                            output int t0);
    logic [10:0] fr;
    fr = {stop_bit, (^d) ^ PAR_ODD[0] ^ bad_par, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 11; i++)
      if (i != 9 || PAR_EN) hold(fr[i], DIV);
  endtask

  task automatic test_reset();
    reset = 1'b1; rxd = 1'b1; out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", out_data); end
    vectors++; if ({overrun, framing_error, parity_error} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 000", {overrun, framing_error, parity_error});
    end
    reset = 1'b0;
    hold(1'b1, 2 * DIV);
    clear_log();
  endtask

  task automatic test_single();
    int t0;
    out_ready = 1'b1;
    clear_log();
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    hold(1'b1, 2 * DIV);
    vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", got_q[0]); end
    end
    vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL single_valid_cycles: got %0d want 1", n_valid); end
    vectors++; if (first_valid !== t0 + LAT) begin
      miscompares++; $display("FAIL single_latency: got %0d want %0d", first_valid - t0, LAT);
    end
    vectors++; if (n_ovr + n_fe + n_pe !== 0) begin
      miscompares++; $display("FAIL single_flags: got ovr=%0d fe=%0d pe=%0d want 0", n_ovr, n_fe, n_pe);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q[$];
    int t, t_drop, exp_ovr;
    exp_ovr = 0; t_drop = -1;
    out_ready = 1'b0;
    clear_log();
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, t);
      if (exp_q.size() < N) exp_q.push_back(8'(b));
      else begin exp_ovr++; t_drop = t; end
    end
    hold(1'b1, DIV);
    vectors++; if (n_ovr !== exp_ovr) begin miscompares++; $display("FAIL ovr_count: got %0d want %0d", n_ovr, exp_ovr); end
    vectors++; if (ovr_cyc !== t_drop + LAT) begin
      miscompares++; $display("FAIL ovr_timing: got %0d want %0d", ovr_cyc, t_drop + LAT);
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_held_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    hold(1'b1, 2 * N + 4);
    vectors++; if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL ovr_drain_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ovr_drain[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_full_pop();
    int t, t5;
    logic [7:0] exp_q[$];
    out_ready = 1'b0;
    clear_log();
    for (int b = 0; b < N; b++) begin
      send_frame(8'(8'h40 + b), 1'b1, 1'b0, t);
      exp_q.push_back(8'(8'h40 + b));
    end
    hold(1'b1, DIV);
    exp_q.push_back(8'h4F);
    // Raise ready so the first pop lands on the same edge as the push into the full FIFO.
    fork
      send_frame(8'h4F, 1'b1, 1'b0, t5);
      begin
        repeat (LAT - 1) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    hold(1'b1, 2 * N + 4);
    vectors++; if (n_ovr !== 0) begin miscompares++; $display("FAIL fullpop_ovr: got %0d want 0", n_ovr); end
    vectors++; if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL fullpop_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL fullpop[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_glitch();
    int t;
    out_ready = 1'b1;
    clear_log();
    hold(1'b0, 3);
    hold(1'b1, 2 * DIV);
    vectors++; if (n_valid + n_fe + n_pe !== 0) begin
      miscompares++; $display("FAIL glitch_quiet: got valid=%0d fe=%0d pe=%0d want 0", n_valid, n_fe, n_pe);
    end
    send_frame(8'h3C, 1'b1, 1'b0, t);
    hold(1'b1, 2 * DIV);
    vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL glitch_count: got %0d want 1", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 8'h3C) begin miscompares++; $display("FAIL glitch_data: got %h want 3c", got_q[0]); end
    end
    vectors++; if (first_valid !== t + LAT) begin
      miscompares++; $display("FAIL glitch_latency: got %0d want %0d", first_valid - t, LAT);
    end
  endtask

  task automatic test_framing();
    int t, t2;
    out_ready = 1'b1;
    clear_log();
    send_frame(8'h55, 1'b0, 1'b0, t);
    hold(1'b0, 30);
    hold(1'b1, 2 * DIV);
    send_frame(8'h66, 1'b1, 1'b0, t2);
    hold(1'b1, 2 * DIV);
    vectors++; if (n_fe !== 1) begin miscompares++; $display("FAIL fe_count: got %0d want 1", n_fe); end
    vectors++; if (fe_cyc !== t + LAT) begin miscompares++; $display("FAIL fe_timing: got %0d want %0d", fe_cyc, t + LAT); end
    vectors++; if (n_pe !== 0) begin miscompares++; $display("FAIL fe_parity: got %0d want 0", n_pe); end
    vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL fe_count_bytes: got %0d want 1", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 8'h66) begin miscompares++; $display("FAIL fe_next_data: got %h want 66", got_q[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    out_ready = 1'b0;
    clear_log();
    send_frame(8'h21, 1'b1, 1'b0, t);
    send_frame(8'h22, 1'b1, 1'b0, t);
    hold(1'b1, DIV);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_prefill: got %b want 1", out_valid); end
    hold(1'b0, DIV);
    hold(1'b1, 3 * DIV);
    hold(1'b0, DIV / 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rxd = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rmid_data: got %h want 00", out_data); end
    vectors++; if ({overrun, framing_error, parity_error} !== 3'b000) begin
      miscompares++; $display("FAIL rmid_flags: got %b want 000", {overrun, framing_error, parity_error});
    end
    hold(1'b1, 3 * DIV);
    clear_log();
    out_ready = 1'b1;
    send_frame(8'h12, 1'b1, 1'b0, t);
    hold(1'b1, 2 * DIV);
    vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL rmid_count: got %0d want 1", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 8'h12) begin miscompares++; $display("FAIL rmid_next: got %h want 12", got_q[0]); end
    end
  endtask

`ifdef PERIDOT_UART_RX_PARITY_EN
  task automatic test_parity();
    int t;
    out_ready = 1'b1;
    clear_log();
    send_frame(8'h03, 1'b1, 1'b1, t);
    hold(1'b1, 2 * DIV);
    vectors++; if (n_pe !== 1) begin miscompares++; $display("FAIL par_err_count: got %0d want 1", n_pe); end
    vectors++; if (pe_cyc !== t + LAT) begin miscompares++; $display("FAIL par_err_timing: got %0d want %0d", pe_cyc, t + LAT); end
    vectors++; if (got_q.size() + n_fe !== 0) begin
      miscompares++; $display("FAIL par_err_discard: got bytes=%0d fe=%0d want 0", got_q.size(), n_fe);
    end
    clear_log();
    send_frame(8'h03, 1'b1, 1'b0, t);
    hold(1'b1, 2 * DIV);
    vectors++; if (got_q.size() !== 1 || n_pe !== 0) begin
      miscompares++; $display("FAIL par_ok: got bytes=%0d pe=%0d want 1/0", got_q.size(), n_pe);
    end else begin
      vectors++; if (got_q[0] !== 8'h03) begin miscompares++; $display("FAIL par_ok_data: got %h want 03", got_q[0]); end
    end
    clear_log();
    send_frame(8'hC3, 1'b0, 1'b1, t);
    hold(1'b1, 2 * DIV);
    vectors++; if (n_fe !== 1 || n_pe !== 1 || fe_cyc !== pe_cyc) begin
      miscompares++; $display("FAIL par_both: got fe=%0d pe=%0d at %0d/%0d want 1/1 same cycle", n_fe, n_pe, fe_cyc, pe_cyc);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic bad_stop, bad_par;
    int t, exp_fe, exp_pe;
    exp_fe = 0; exp_pe = 0;
    out_ready = 1'b1;
    clear_log();
    for (int k = 0; k < 16; k++) begin
      d        = 8'($urandom);
      bad_stop = ($urandom_range(0, 4) == 0);
      bad_par  = PAR_EN && ($urandom_range(0, 4) == 0);
      send_frame(d, !bad_stop, bad_par, t);
      if (!bad_stop && !bad_par) exp_q.push_back(d);
      if (bad_stop) exp_fe++;
      if (bad_par) exp_pe++;
      if (bad_stop) begin
        hold(1'b0, $urandom_range(0, 20));
        hold(1'b1, DIV + $urandom_range(0, DIV));
      end else begin
        hold(1'b1, $urandom_range(0, DIV));
      end
    end
    hold(1'b1, 2 * DIV);
    vectors++; if (n_fe !== exp_fe) begin miscompares++; $display("FAIL rand_fe: got %0d want %0d", n_fe, exp_fe); end
    vectors++; if (n_pe !== exp_pe) begin miscompares++; $display("FAIL rand_pe: got %0d want %0d", n_pe, exp_pe); end
    vectors++; if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int t, k, exp_ovr;
    exp_ovr = 0;
    k = $urandom_range(1, 7);
    out_ready = 1'b0;
    clear_log();
    for (int i = 0; i < k; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 1'b0, t);
      if (exp_q.size() < N) exp_q.push_back(d);
      else exp_ovr++;
    end
    hold(1'b1, DIV);
    out_ready = 1'b1;
    hold(1'b1, 3 * N);
    vectors++; if (n_ovr !== exp_ovr) begin miscompares++; $display("FAIL burst_ovr: got %0d want %0d", n_ovr, exp_ovr); end
    vectors++; if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL burst_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL burst[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL burst_empty: got %b want 0", out_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clear_log();
    test_reset();
    test_single();
    test_overrun();
    test_full_pop();
    test_glitch();
    test_framing();
    test_reset_mid();
`ifdef PERIDOT_UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_burst();
    test_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
